// File: rtl/mult_div.sv
// Iterative 32x32 signed multiply / restoring divide into HI/LO, fixed 33-cycle latency.
// Define MULT_DIV_UNSIGNED_EN to add the usign input (multu/divu).
module mult_div (
  input  logic        clock,
  input  logic        reset,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic        usign,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic        MDcontrol,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        Div0
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        op_div, sign_a, sign_res;

  logic        sgn, sa, sb;
`ifdef MULT_DIV_UNSIGNED_EN
  assign sgn = ~usign;
`else
  assign sgn = 1'b1;
`endif
  assign sa = sgn & A[31];
  assign sb = sgn & B[31];

  logic [31:0] mag_a, mag_b;
  assign mag_a = sa ? -A : A;
  assign mag_b = sb ? -B : B;

  // Multiply step: LSB-first shift-add, multiplier sits in the low half of acc.
  logic [32:0] madd;
  logic [63:0] mult_nxt;
  assign madd     = {1'b0, acc[63:32]} + {1'b0, opb};
  assign mult_nxt = acc[0] ? {madd, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};

  // Divide step: 33-bit partial remainder so divisors >= 2^31 still compare correctly.
  logic [32:0] rem_sh, rem_sub;
  logic [63:0] div_nxt;
  assign rem_sh  = {acc[63:32], acc[31]};
  assign rem_sub = rem_sh - {1'b0, opb};
  assign div_nxt = rem_sub[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                               : {rem_sub[31:0], acc[30:0], 1'b1};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = sign_res ? -acc : acc;
  assign quo_fix  = sign_res ? -acc[31:0] : acc[31:0];
  assign rem_fix  = sign_a ? -acc[63:32] : acc[63:32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_res <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      Div0 <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (MDcontrol && B == 32'd0) begin
            Div0 <= 1'b1;
          end else begin
            op_div   <= MDcontrol;
            sign_a   <= sa;
            sign_res <= sa ^ sb;
            opb      <= MDcontrol ? mag_b : mag_a;
            acc      <= MDcontrol ? {32'd0, mag_a} : {32'd0, mag_b};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= op_div ? div_nxt : mult_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FINISH;
        end
        FINISH: begin
          if (op_div) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
